// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default latencies, FSM states.
// Codes MD_MADD..MD_MSUBU are only acted on when MD_MADD_EN is defined.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int unsigned MD_MULT_LAT = 5;
    localparam int unsigned MD_DIV_LAT  = 10;

    typedef enum logic {
        IDLE,
        RUN
    } md_state_e;

    function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the execute stage (master) and the multiply/divide unit (slave).
interface md_unit_if;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, srca, srcb,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdop, srca, srcb,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_busy_timer.sv
// Loadable down-counter owning the busy flag; done_o is high in the last busy cycle so the
// owner commits on the same edge that busy falls.
module md_busy_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            busy_d = (load_val_i != '0);
        end else if (busy_q) begin
            cnt_d  = cnt_q - Width'(1);
            busy_d = (cnt_q != Width'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == Width'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results land on the edge busy falls.
// Define MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (otherwise those codes are NOPs).
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  md
);

    localparam int unsigned CntW = $clog2(md_max(MULT_LAT, DIV_LAT) + 1);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d, cur_op;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic            busy, done, is_long, accept;
    logic [CntW-1:0] load_val;

    assign cur_op = md_op_e'(md.mdop);
    assign accept = md.start && (state_q == IDLE) && !busy;

    always_comb begin
        is_long  = 1'b0;
        load_val = '0;
        case (cur_op)
            MD_MULT, MD_MULTU: begin
                is_long  = 1'b1;
                load_val = CntW'(MULT_LAT);
            end
            MD_DIV, MD_DIVU: begin
                is_long  = 1'b1;
                load_val = CntW'(DIV_LAT);
            end
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                is_long  = 1'b1;
                load_val = CntW'(MULT_LAT);
            end
`endif
            default: ;
        endcase
    end

    md_busy_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (accept && is_long),
        .load_val_i (load_val),
        .busy_o     (busy),
        .done_o     (done)
    );

    logic [63:0] prod_s, prod_u;
    logic        signed_div;
    logic [31:0] dvd, dvs, quo_mag, rem_mag, quo, rem;

    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        signed_div = (op_q == MD_DIV);
        dvd        = (signed_div && a_q[31]) ? -a_q : a_q;
        dvs        = (signed_div && b_q[31]) ? -b_q : b_q;
        // Divide by zero never commits; a dummy divisor keeps the datapath X-free.
        if (dvs == '0) dvs = 32'd1;
        quo_mag    = dvd / dvs;
        rem_mag    = dvd % dvs;
        quo        = (signed_div && (a_q[31] ^ b_q[31])) ? -quo_mag : quo_mag;
        rem        = (signed_div && a_q[31]) ? -rem_mag : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_long) begin
                        op_d    = cur_op;
                        a_d     = md.srca;
                        b_d     = md.srcb;
                        state_d = RUN;
                    end else if (cur_op == MD_MTHI) begin
                        hi_d = md.srca;
                    end else if (cur_op == MD_MTLO) begin
                        lo_d = md.srca;
                    end
                end
            end
            RUN: begin
                if (done) begin
                    state_d = IDLE;
                    case (op_q)
                        MD_MULT:  {hi_d, lo_d} = prod_s;
                        MD_MULTU: {hi_d, lo_d} = prod_u;
                        MD_DIV, MD_DIVU: begin
                            if (b_q != '0) {hi_d, lo_d} = {rem, quo};
                        end
`ifdef MD_MADD_EN
                        MD_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        MD_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                        MD_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                        MD_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MD_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = busy;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO and busy length, monitor checks them.
module tb_md_unit;

    localparam int unsigned MultLat = 5;
    localparam int unsigned DivLat  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(
        .MULT_LAT (MultLat),
        .DIV_LAT  (DivLat)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    typedef struct {
        string       name;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    bit          active   = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: updates m_hi/m_lo, returns busy length.
    function automatic int model_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        int          lat;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 0;
        case (op)
            4'd1: begin p = sa * sb; {m_hi, m_lo} = p; lat = MultLat; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; lat = MultLat; end
            4'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                lat = DivLat;
            end
            4'd4: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                lat = DivLat;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MD_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd7 || op == 4'd9) p = sa * sb;
                else p = {32'd0, a} * {32'd0, b};
                if (op <= 4'd8) {m_hi, m_lo} = {m_hi, m_lo} + p;
                else {m_hi, m_lo} = {m_hi, m_lo} - p;
                lat = MultLat;
            end
`endif
            default: ;
        endcase
        return lat;
    endfunction

    task automatic push(input string name, input int lat, input logic [31:0] oh,
                        input logic [31:0] ol);
        exp_t e;
        e.name   = name;
        e.lat    = lat;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.old_hi = oh;
        e.old_lo = ol;
        sb_q.push_back(e);
    endtask

    task automatic idle_check(input string name);
        push(name, 0, m_hi, m_lo);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle the model says is idle.
    task automatic go(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
        logic [31:0] oh = m_hi;
        logic [31:0] ol = m_lo;
        int          lat;
        bus.start = 1'b1;
        bus.mdop  = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mdop  = 4'($urandom);
        bus.srca  = $urandom;
        bus.srcb  = $urandom;
        lat = model_op(op, a, b);
        push(name, lat, oh, ol);
        repeat (lat) begin
            @(posedge clk); #1;
            bus.srca = $urandom;
            bus.srcb = $urandom;
        end
    endtask

    initial begin : monitor
        exp_t cur;
        int   cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (active) begin
                if (bus.busy) begin
                    cnt++;
                    check32({cur.name, " hold hi"}, bus.hi, cur.old_hi);
                    check32({cur.name, " hold lo"}, bus.lo, cur.old_lo);
                    if (cnt > cur.lat + 4) begin
                        check32({cur.name, " busy timeout"}, 32'(cnt), 32'(cur.lat));
                        active = 1'b0;
                    end
                end else begin
                    check32({cur.name, " busy cycles"}, 32'(cnt), 32'(cur.lat));
                    check32({cur.name, " hi"}, bus.hi, cur.hi);
                    check32({cur.name, " lo"}, bus.lo, cur.lo);
                    active = 1'b0;
                end
            end else if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                if (cur.lat == 0) begin
                    check32({cur.name, " busy"}, {31'd0, bus.busy}, 32'd0);
                    check32({cur.name, " hi"}, bus.hi, cur.hi);
                    check32({cur.name, " lo"}, bus.lo, cur.lo);
                end else begin
                    check32({cur.name, " busy rise"}, {31'd0, bus.busy}, 32'd1);
                    cnt    = bus.busy ? 1 : 0;
                    active = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] oh, ol;
        int          lat;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mdop  = '0;
        bus.srca  = '0;
        bus.srcb  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_check("reset");

        go("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3);
        go("multu max*max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        go("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
        go("divu 7/0", 4'd4, 32'd7, 32'd0);
        go("mthi", 4'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        go("mtlo", 4'd6, 32'h9ABC_DEF0, 32'h0);
        go("div min/-1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        go("div by zero", 4'd3, 32'h1234_0000, 32'd0);
        go("nop code 15", 4'd15, 32'h5555_5555, 32'h1);

        // MULT followed by a DIV request in its second busy cycle, which must be dropped.
        oh = m_hi;
        ol = m_lo;
        bus.start = 1'b1; bus.mdop = 4'd1; bus.srca = 32'd1000; bus.srcb = 32'hFFFF_FFF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = model_op(4'd1, 32'd1000, 32'hFFFF_FFF0);
        push("mult with ignored div", lat, oh, ol);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdop = 4'd3; bus.srca = 32'd77; bus.srcb = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        idle_check("after ignored div");

`ifdef MD_MADD_EN
        go("madd mthi", 4'd5, 32'h0, 32'h0);
        go("madd mtlo", 4'd6, 32'hFFFF_FFFF, 32'h0);
        go("maddu 1*1", 4'd8, 32'd1, 32'd1);
        go("msub -3*5", 4'd9, 32'hFFFF_FFFD, 32'd5);
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
                3: b = -$urandom_range(1, 9);
                default: ;
            endcase
            go($sformatf("rand%0d op%0d", i, op), op, a, b);
        end

        // Reset in the fourth busy cycle of a DIV must abort it with no late commit.
        bus.start = 1'b1; bus.mdop = 4'd3; bus.srca = 32'd100; bus.srcb = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 12; i++) idle_check($sformatf("post-reset idle %0d", i));

        repeat (3) begin @(posedge clk); #1; end
        check32("scoreboard drain", 32'(sb_q.size()), 32'd0);
        check32("monitor idle", {31'd0, active}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Accepts operands from the same forwarded SrcA/SrcB path and returns results through the HI/LO registers.
- Completion is signalled to the hazard unit through a busy/start handshake.
- Owns HI and LO; MFHI/MFLO read the output ports directly.

Parameters:
- MULT_LAT, 5, cycles busy after a multiply (or multiply-accumulate) start; must be ≥1.
- DIV_LAT, 10, cycles busy after a divide start; must be ≥1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; op is decoded in that cycle.
- mdop  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7..10 defined under Optional Feature; others treated as NOP.
- srca  input  32  first operand (rs).
- srcb  input  32  second operand (rt).
- busy  output  1  high while an operation is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, state IDLE. Reset mid-operation aborts it and discards the pending result.
- States:
  - IDLE: start with MULT/MULTU/DIV/DIVU latches operands, sets counter to MULT_LAT or DIV_LAT, and moves to RUN. busy goes 1 on that same edge.
  - RUN: counter decrements each cycle. At counter==1 the next edge writes hi/lo, clears busy and returns to IDLE.
  - Net effect: busy is high for exactly LAT cycles, and new hi/lo are visible in the first cycle busy is 0.
- MTHI/MTLO with start in IDLE: hi (or lo) ← srca on that edge. No busy; other register unchanged.
- Any start while busy=1 is ignored entirely. The pipeline must stall; the verifier flags it as a protocol violation.
- hi/lo keep their old values throughout RUN; partial results are never exposed.
- Arithmetic:
  - MULT: {hi,lo} = signed 32×32 → 64.
  - MULTU: {hi,lo} = unsigned 32×32 → 64.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (srcb==0): full DIV_LAT busy period, hi/lo unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Operands are sampled only at the start edge. Later changes on srca/srcb have no effect.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: mdop 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are accepted.
  - Each does {hi,lo} ← {hi,lo} ± product (signed or unsigned), modulo 2^64.
  - Uses MULT_LAT.
  - {hi,lo} is read at commit time, which equals its value at start since no writes occur while busy.
- Undefined: codes 7..10 are NOP (no busy, no state change).

Decomposition:
- Shared package md_pkg holds:
  - mdop encodings (MD_NOP … MD_MSUBU);
  - default latency constants MD_MULT_LAT=5, MD_DIV_LAT=10;
  - state encoding IDLE/RUN.
- The ALU op package stays separate.
- One sub-module, md_busy_timer: loadable down-counter with load value and done pulse; owns the busy flag.

Test Plan:
- reset, then start MULT srca=0xFFFFFFFE (−2) srcb=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- start MULTU 0xFFFFFFFF×0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- start DIV −7/2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 → busy 10 cycles, hi/lo unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → busy never rises; hi/lo take the values on the respective edges.
- start MULT, then start DIV at cycle 2 of busy → DIV ignored; busy falls after 5 cycles total; MULT result committed.
- start DIV, assert reset at cycle 4 → next cycle busy=0, hi=lo=0; no late commit afterwards. With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0.
